mips_ctrl_fsm_pla: RTL and testbench



---
 rtl/mips_ctrl_fsm_pla.sv | 113 +++++++++++
 tb/tb_mips_ctrl_fsm_pla.sv | 280 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mips_ctrl_fsm_pla.sv
// Runtime-programmable PLA controller: {op,state} -> {next_state,ctl} through
// writable AND/OR planes, with run/hold, readback and sticky illegal-state flag.
module mips_ctrl_fsm_pla #(
  parameter int OP_W   = 6,
  parameter int ST_W   = 4,
  parameter int CTL_W  = 19,
  parameter int NTERMS = 16,
  localparam int IN_W  = OP_W + ST_W,
  localparam int OUT_W = CTL_W + ST_W,
  localparam int AW    = $clog2(NTERMS),
  localparam int PW    = (IN_W > OUT_W) ? IN_W : OUT_W
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             run,
  input  logic [OP_W-1:0]  op,
  output logic [CTL_W-1:0] ctl,
  output logic [ST_W-1:0]  state,
  output logic             illegal,
  input  logic             clr_illegal,
  input  logic             prog_we,
  input  logic [1:0]       prog_sel,
  input  logic [AW-1:0]    prog_addr,
  input  logic [PW-1:0]    prog_wdata,
  output logic [PW-1:0]    prog_rdata,
  output logic             prog_err
);

  logic [IN_W-1:0]   and_val  [NTERMS];
  logic [IN_W-1:0]   and_care [NTERMS];
  logic [OUT_W-1:0]  or_mask  [NTERMS];
  logic [NTERMS-1:0] valid;

  logic [IN_W-1:0]   pla_in;
  logic [NTERMS-1:0] hit;
  logic [OUT_W-1:0]  or_out;
  logic              any_hit;
  logic              wr_ok;

  logic [ST_W-1:0]   state_nxt;
  logic              illegal_nxt;
  logic [PW-1:0]     rdata_nxt;

  assign pla_in = {op, state};

  // All matching terms contribute; there is deliberately no priority.
  always_comb begin
    hit    = '0;
    or_out = '0;
    for (int t = 0; t < NTERMS; t++) begin
      hit[t] = valid[t] && ((pla_in & and_care[t]) == (and_val[t] & and_care[t]));
      if (hit[t]) or_out = or_out | or_mask[t];
    end
  end

  assign any_hit = |hit;
  assign ctl     = run ? or_out[CTL_W-1:0] : '0;
  assign wr_ok   = prog_we && !run && !reset;

  // Clear is applied first so that a same-cycle illegal set overrides it.
  always_comb begin
    state_nxt   = state;
    illegal_nxt = illegal;
    if (clr_illegal) illegal_nxt = 1'b0;
    if (run) begin
      if (any_hit) begin
        state_nxt = or_out[OUT_W-1:CTL_W];
      end else begin
        state_nxt   = '0;
        illegal_nxt = 1'b1;
      end
    end
  end

  always_comb begin
    rdata_nxt = '0;
    unique case (prog_sel)
      2'd0: rdata_nxt = PW'(and_val[prog_addr]);
      2'd1: rdata_nxt = PW'(and_care[prog_addr]);
      2'd2: rdata_nxt = PW'(or_mask[prog_addr]);
      2'd3: rdata_nxt = PW'(valid[prog_addr]);
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= '0;
      illegal    <= 1'b0;
      prog_err   <= 1'b0;
      prog_rdata <= '0;
      valid      <= '0;
    end else begin
      state      <= state_nxt;
      illegal    <= illegal_nxt;
      prog_err   <= prog_we && run;
      prog_rdata <= rdata_nxt;
      if (wr_ok && prog_sel == 2'd3) valid[prog_addr] <= prog_wdata[0];
    end
  end

  // Plane contents are not reset; terms are gated off by valid instead.
  always_ff @(posedge clk) begin
    if (wr_ok) begin
      case (prog_sel)
        2'd0:    and_val[prog_addr]  <= prog_wdata[IN_W-1:0];
        2'd1:    and_care[prog_addr] <= prog_wdata[IN_W-1:0];
        2'd2:    or_mask[prog_addr]  <= prog_wdata[OUT_W-1:0];
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mips_ctrl_fsm_pla.sv
// Bench for mips_ctrl_fsm_pla: directed scenarios plus randomized traffic
// compared against a term-list model of the programmable planes.
module tb_mips_ctrl_fsm_pla;
  localparam int OP_W = 6, ST_W = 4, CTL_W = 19, NTERMS = 16;
  localparam int IN_W = 10, OUT_W = 23, AW = 4, PW = 23;

  logic             clk, reset, run, clr_illegal, prog_we, illegal, prog_err;
  logic [OP_W-1:0]  op;
  logic [CTL_W-1:0] ctl;
  logic [ST_W-1:0]  state;
  logic [1:0]       prog_sel;
  logic [AW-1:0]    prog_addr;
  logic [PW-1:0]    prog_wdata, prog_rdata;

  int checks = 0;
  int errors = 0;

  mips_ctrl_fsm_pla #(.OP_W(OP_W), .ST_W(ST_W), .CTL_W(CTL_W), .NTERMS(NTERMS)) dut (
    .clk(clk), .reset(reset), .run(run), .op(op), .ctl(ctl), .state(state),
    .illegal(illegal), .clr_illegal(clr_illegal), .prog_we(prog_we),
    .prog_sel(prog_sel), .prog_addr(prog_addr), .prog_wdata(prog_wdata),
    .prog_rdata(prog_rdata), .prog_err(prog_err)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Reference model: a list of terms and the visible registers.
  logic [IN_W-1:0]  m_val  [NTERMS];
  logic [IN_W-1:0]  m_care [NTERMS];
  logic [OUT_W-1:0] m_or   [NTERMS];
  bit               m_vld  [NTERMS];
  logic [ST_W-1:0]  m_state = '0;
  logic             m_ill = 1'b0, m_err = 1'b0;
  logic [PW-1:0]    m_rd = '0;

  function automatic void m_eval(input logic [OP_W-1:0] o, input logic [ST_W-1:0] s,
                                 output logic found, output logic [OUT_W-1:0] res);
    found = 1'b0;
    res   = '0;
    for (int t = 0; t < NTERMS; t++)
      if (m_vld[t] && ((({o, s} ^ m_val[t]) & m_care[t]) == '0)) begin
        found = 1'b1;
        res   = res | m_or[t];
      end
  endfunction

  task automatic model_edge();
    logic found;
    logic [OUT_W-1:0] res;
    logic [PW-1:0] rd;
    m_eval(op, m_state, found, res);
    case (prog_sel)
      2'd0:    rd = PW'(m_val[prog_addr]);
      2'd1:    rd = PW'(m_care[prog_addr]);
      2'd2:    rd = PW'(m_or[prog_addr]);
      default: rd = PW'(m_vld[prog_addr]);
    endcase
    if (reset) begin
      m_state = '0; m_ill = 1'b0; m_err = 1'b0; m_rd = '0;
      for (int t = 0; t < NTERMS; t++) m_vld[t] = 1'b0;
    end else begin
      m_err = prog_we && run;
      m_rd  = rd;
      m_ill = (run && !found) ? 1'b1 : (clr_illegal ? 1'b0 : m_ill);
      if (run) m_state = found ? res[OUT_W-1:CTL_W] : '0;
      if (prog_we && !run)
        case (prog_sel)
          2'd0:    m_val[prog_addr]  = prog_wdata[IN_W-1:0];
          2'd1:    m_care[prog_addr] = prog_wdata[IN_W-1:0];
          2'd2:    m_or[prog_addr]   = prog_wdata[OUT_W-1:0];
          default: m_vld[prog_addr]  = prog_wdata[0];
        endcase
    end
  endtask

  task automatic tick();
    model_edge();
    @(posedge clk);
    #1;
  endtask

  task automatic prog(input logic [1:0] s, input logic [AW-1:0] a, input logic [PW-1:0] d);
    prog_sel = s; prog_addr = a; prog_wdata = d; prog_we = 1'b1;
    tick();
    prog_we = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1; run = 1'b0; op = '0; clr_illegal = 1'b0; prog_we = 1'b0;
    prog_sel = '0; prog_addr = '0; prog_wdata = '0;
    tick(); tick();
    reset = 1'b0;
    checks++; if (state !== 4'h0) begin errors++; $display("FAIL reset_state got %h want 0", state); end
    checks++; if (illegal !== 1'b0) begin errors++; $display("FAIL reset_illegal got %b want 0", illegal); end
    checks++; if (prog_err !== 1'b0) begin errors++; $display("FAIL reset_prog_err got %b want 0", prog_err); end
    checks++; if (prog_rdata !== '0) begin errors++; $display("FAIL reset_rdata got %h want 0", prog_rdata); end
    checks++; if (ctl !== '0) begin errors++; $display("FAIL reset_ctl got %h want 0", ctl); end
  endtask

  task automatic test_no_terms();
    run = 1'b1; op = OP_W'($urandom); #1;
    checks++; if (ctl !== '0) begin errors++; $display("FAIL empty_ctl got %h want 0", ctl); end
    tick();
    checks++; if (illegal !== 1'b1) begin errors++; $display("FAIL empty_illegal got %b want 1", illegal); end
    checks++; if (state !== 4'h0) begin errors++; $display("FAIL empty_state got %h want 0", state); end
    clr_illegal = 1'b1;
    tick();
    checks++; if (illegal !== 1'b1) begin errors++; $display("FAIL set_beats_clear got %b want 1", illegal); end
    run = 1'b0;
    tick();
    clr_illegal = 1'b0;
    checks++; if (illegal !== 1'b0) begin errors++; $display("FAIL clear_illegal got %b want 0", illegal); end
    run = 1'b1;
    tick();
    run = 1'b0;
    checks++; if (illegal !== 1'b1) begin errors++; $display("FAIL reset_illegal_again got %b want 1", illegal); end
  endtask

  task automatic test_alternate();
    logic [CTL_W-1:0] exp_ctl;
    logic [ST_W-1:0]  exp_st;
    run = 1'b0;
    prog(2'd0, 4'd0, 23'h000); prog(2'd1, 4'd0, 23'h00F);
    prog(2'd2, 4'd0, {4'h1, 19'h00401}); prog(2'd3, 4'd0, 23'h1);
    prog(2'd0, 4'd1, 23'h001); prog(2'd1, 4'd1, 23'h00F);
    prog(2'd2, 4'd1, {4'h0, 19'h00002}); prog(2'd3, 4'd1, 23'h1);
    clr_illegal = 1'b1; tick(); clr_illegal = 1'b0;
    run = 1'b1;
    for (int i = 0; i < 6; i++) begin
      op = OP_W'($urandom); #1;
      exp_ctl = (i % 2 == 0) ? 19'h00401 : 19'h00002;
      exp_st  = (i % 2 == 0) ? 4'h1 : 4'h0;
      checks++; if (ctl !== exp_ctl) begin errors++; $display("FAIL alt_ctl[%0d] got %h want %h", i, ctl, exp_ctl); end
      tick();
      checks++; if (state !== exp_st) begin errors++; $display("FAIL alt_state[%0d] got %h want %h", i, state, exp_st); end
    end
    run = 1'b0;
    checks++; if (illegal !== 1'b0) begin errors++; $display("FAIL alt_illegal got %b want 0", illegal); end
  endtask

  task automatic test_opcode();
    run = 1'b0;
    prog(2'd0, 4'd2, {13'h0, 6'h23, 4'h1}); prog(2'd1, 4'd2, 23'h3FF);
    prog(2'd2, 4'd2, {4'h2, 19'h0}); prog(2'd3, 4'd2, 23'h1);
    prog(2'd1, 4'd1, 23'h3FF);
    op = 6'h00; run = 1'b1; tick();
    checks++; if (state !== 4'h1) begin errors++; $display("FAIL op_enter_s1 got %h want 1", state); end
    op = 6'h23; #1;
    checks++; if (ctl !== '0) begin errors++; $display("FAIL op23_ctl got %h want 0", ctl); end
    tick();
    checks++; if (state !== 4'h2) begin errors++; $display("FAIL op23_state got %h want 2", state); end
    tick();
    checks++; if (state !== 4'h0 || illegal !== 1'b1) begin errors++; $display("FAIL uncovered_s2 got st=%h ill=%b want st=0 ill=1", state, illegal); end
    run = 1'b0; clr_illegal = 1'b1; tick(); clr_illegal = 1'b0;
    op = 6'h00; run = 1'b1; tick();
    op = 6'h2B; tick();
    run = 1'b0;
    checks++; if (state !== 4'h0 || illegal !== 1'b1) begin errors++; $display("FAIL op2b got st=%h ill=%b want st=0 ill=1", state, illegal); end
  endtask

  task automatic test_prog_err();
    run = 1'b0; clr_illegal = 1'b1;
    prog(2'd2, 4'd3, 23'h5A5A5A);
    clr_illegal = 1'b0;
    op = 6'h00; run = 1'b1;
    prog_we = 1'b1; prog_sel = 2'd2; prog_addr = 4'd3; prog_wdata = 23'h123456;
    tick();
    prog_we = 1'b0;
    checks++; if (prog_err !== 1'b1) begin errors++; $display("FAIL prog_err_pulse got %b want 1", prog_err); end
    checks++; if (prog_rdata !== 23'h5A5A5A) begin errors++; $display("FAIL err_rdata_old got %h want 5a5a5a", prog_rdata); end
    tick();
    run = 1'b0;
    checks++; if (prog_err !== 1'b0) begin errors++; $display("FAIL prog_err_width got %b want 0", prog_err); end
    checks++; if (prog_rdata !== 23'h5A5A5A) begin errors++; $display("FAIL err_discard got %h want 5a5a5a", prog_rdata); end
    checks++; if (state !== 4'h0 || illegal !== 1'b0) begin errors++; $display("FAIL err_run_path got st=%h ill=%b want st=0 ill=0", state, illegal); end
  endtask

  task automatic test_readback();
    run = 1'b0;
    prog(2'd0, 4'd5, 23'h111);
    prog_we = 1'b1; prog_sel = 2'd0; prog_addr = 4'd5; prog_wdata = 23'h7FFAA5;
    tick();
    prog_we = 1'b0;
    checks++; if (prog_rdata !== 23'h000111) begin errors++; $display("FAIL rd_during_wr got %h want 000111", prog_rdata); end
    tick();
    checks++; if (prog_rdata !== 23'h0002A5) begin errors++; $display("FAIL rd_and_val got %h want 0002a5", prog_rdata); end
    prog(2'd3, 4'd6, 23'h7FFFFE);
    tick();
    checks++; if (prog_rdata !== 23'h0) begin errors++; $display("FAIL rd_valid0 got %h want 0", prog_rdata); end
    prog(2'd1, 4'd2, 23'h7FF3FF);
    tick();
    checks++; if (prog_rdata !== 23'h0003FF) begin errors++; $display("FAIL rd_care got %h want 0003ff", prog_rdata); end
  endtask

  task automatic test_hold();
    op = 6'h00; run = 1'b1; tick();
    checks++; if (state !== 4'h1) begin errors++; $display("FAIL hold_enter got %h want 1", state); end
    run = 1'b0; #1;
    checks++; if (ctl !== '0) begin errors++; $display("FAIL hold_ctl got %h want 0", ctl); end
    for (int i = 0; i < 5; i++) begin
      op = OP_W'($urandom);
      tick();
      checks++; if (state !== 4'h1) begin errors++; $display("FAIL hold_state[%0d] got %h want 1", i, state); end
    end
    op = 6'h00; run = 1'b1; #1;
    checks++; if (ctl !== 19'h00002) begin errors++; $display("FAIL resume_ctl got %h want 00002", ctl); end
    tick();
    run = 1'b0;
    checks++; if (state !== 4'h0) begin errors++; $display("FAIL resume_state got %h want 0", state); end
  endtask

  task automatic test_reset_mid();
    op = 6'h00; run = 1'b1; tick();
    reset = 1'b1; prog_we = 1'b1; prog_sel = 2'd0; prog_addr = 4'd5; prog_wdata = 23'h0F0;
    tick();
    reset = 1'b0; prog_we = 1'b0; run = 1'b0;
    checks++; if (state !== 4'h0) begin errors++; $display("FAIL mid_reset_state got %h want 0", state); end
    checks++; if (prog_err !== 1'b0) begin errors++; $display("FAIL mid_reset_err got %b want 0", prog_err); end
    run = 1'b1; #1;
    checks++; if (ctl !== '0) begin errors++; $display("FAIL mid_reset_ctl got %h want 0", ctl); end
    tick();
    run = 1'b0;
    checks++; if (illegal !== 1'b1) begin errors++; $display("FAIL mid_reset_illegal got %b want 1", illegal); end
    prog_sel = 2'd0; prog_addr = 4'd5; tick();
    checks++; if (prog_rdata !== 23'h0002A5) begin errors++; $display("FAIL reset_write_discard got %h want 0002a5", prog_rdata); end
    prog_sel = 2'd3; prog_addr = 4'd0; tick();
    checks++; if (prog_rdata !== 23'h0) begin errors++; $display("FAIL reset_invalidate got %h want 0", prog_rdata); end
  endtask

  task automatic test_random();
    logic found;
    logic [OUT_W-1:0] res;
    logic [CTL_W-1:0] exp_ctl;
    reset = 1'b1; tick(); reset = 1'b0; run = 1'b0;
    for (int t = 0; t < NTERMS; t++) begin
      prog(2'd0, AW'(t), PW'($urandom));
      prog(2'd1, AW'(t), PW'($urandom & $urandom & $urandom));
      prog(2'd2, AW'(t), PW'($urandom));
      prog(2'd3, AW'(t), PW'($urandom_range(0, 3) != 0));
    end
    for (int i = 0; i < 500; i++) begin
      run         = ($urandom_range(0, 9) < 7);
      op          = OP_W'($urandom);
      clr_illegal = ($urandom_range(0, 15) == 0);
      prog_we     = ($urandom_range(0, 7) == 0);
      prog_sel    = 2'($urandom);
      prog_addr   = AW'($urandom);
      prog_wdata  = PW'($urandom);
      reset       = ($urandom_range(0, 63) == 0);
      #1;
      m_eval(op, m_state, found, res);
      exp_ctl = run ? res[CTL_W-1:0] : '0;
      checks++; if (ctl !== exp_ctl) begin errors++; $display("FAIL rnd_ctl[%0d] got %h want %h", i, ctl, exp_ctl); end
      tick();
      checks++; if (state !== m_state) begin errors++; $display("FAIL rnd_state[%0d] got %h want %h", i, state, m_state); end
      checks++; if (illegal !== m_ill) begin errors++; $display("FAIL rnd_illegal[%0d] got %b want %b", i, illegal, m_ill); end
      checks++; if (prog_err !== m_err) begin errors++; $display("FAIL rnd_prog_err[%0d] got %b want %b", i, prog_err, m_err); end
      checks++; if (prog_rdata !== m_rd) begin errors++; $display("FAIL rnd_rdata[%0d] got %h want %h", i, prog_rdata, m_rd); end
    end
    reset = 1'b0; prog_we = 1'b0; run = 1'b0; clr_illegal = 1'b0;
  endtask

  initial begin
    test_reset();
    test_no_terms();
    test_alternate();
    test_opcode();
    test_prog_err();
    test_readback();
    test_hold();
    test_reset_mid();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
